// File: rtl/button_enable_gen.sv
// button_enable_gen: debounces a raw push-button into single-cycle enable pulses with optional auto-repeat.
module button_enable_gen #(
  parameter int SAMPLE_DIV   = 1000,
  parameter int STABLE_COUNT = 4,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic enable,
  output logic level_out,
  output logic repeat_active
);
  localparam int RPT_MAX = REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DIV_W   = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  localparam int STB_W   = STABLE_COUNT > 1 ? $clog2(STABLE_COUNT) : 1;
  localparam int RPT_W   = RPT_MAX > 1 ? $clog2(RPT_MAX) : 1;
  localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2;

  logic s1, s2;
  logic [DIV_W-1:0] div_cnt;
  logic [STB_W-1:0] stable_cnt;
  logic [RPT_W-1:0] rpt_cnt, rpt_next;
  logic [1:0] state, state_next;
  logic tick, flip, rise, fall, leave, counting, rpt_hit, pulse;

  assign tick = div_cnt == DIV_W'(SAMPLE_DIV - 1);
  assign flip = tick && (s2 != level_out) && stable_cnt == STB_W'(STABLE_COUNT - 1);
  assign rise = flip && s2;
  assign fall = flip && !s2;
  assign leave = state != IDLE && fall;
  assign counting = tick && (state == REPEAT || (state == DELAY && REPEAT_DELAY != 0));
  assign rpt_hit = tick && ((state == DELAY && REPEAT_DELAY != 0 && 32'(rpt_cnt) == REPEAT_DELAY - 1) ||
                            (state == REPEAT && 32'(rpt_cnt) == REPEAT_RATE - 1));

  // Release takes priority over a repeat expiry landing on the same tick.
  always_comb begin
    pulse = (state == IDLE && rise) || (!leave && rpt_hit);
    state_next = leave ? IDLE : (state == IDLE && rise) ? DELAY : rpt_hit ? REPEAT : state;
    rpt_next = (leave || state == IDLE || rpt_hit) ? '0 : counting ? rpt_cnt + 1'b1 : rpt_cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      div_cnt <= '0;
      stable_cnt <= '0;
      level_out <= 1'b0;
    end else begin
      s1 <= button_in;
      s2 <= s1;
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      stable_cnt <= !tick ? stable_cnt : (s2 == level_out || flip) ? '0 : stable_cnt + 1'b1;
      level_out <= flip ? s2 : level_out;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rpt_cnt <= '0;
      enable <= 1'b0;
      repeat_active <= 1'b0;
    end else begin
      state <= state_next;
      rpt_cnt <= rpt_next;
      enable <= pulse;
      repeat_active <= state_next == REPEAT;
    end
  end
endmodule

// File: tb/tb_button_enable_gen.sv
// tb_button_enable_gen: three parameterisations checked every cycle against a tick-counting behavioural model.
module tb_button_enable_gen;
  logic clock = 1'b0, reset, button;
  logic en_a, lv_a, ra_a, en_b, lv_b, ra_b, en_c, lv_c, ra_c;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic s1, s2, lvl, held, en, ra;
    int cyc, run, tsp;
  } mdl_t;
  mdl_t ma, mb, mc;

  always #5 clock = ~clock;

  button_enable_gen #(.SAMPLE_DIV(1), .STABLE_COUNT(4), .REPEAT_DELAY(0), .REPEAT_RATE(1)) dut_a (
    .clock(clock), .reset(reset), .button_in(button), .enable(en_a), .level_out(lv_a), .repeat_active(ra_a));
  button_enable_gen #(.SAMPLE_DIV(1), .STABLE_COUNT(4), .REPEAT_DELAY(8), .REPEAT_RATE(3)) dut_b (
    .clock(clock), .reset(reset), .button_in(button), .enable(en_b), .level_out(lv_b), .repeat_active(ra_b));
  button_enable_gen #(.SAMPLE_DIV(5), .STABLE_COUNT(2), .REPEAT_DELAY(3), .REPEAT_RATE(2)) dut_c (
    .clock(clock), .reset(reset), .button_in(button), .enable(en_c), .level_out(lv_c), .repeat_active(ra_c));

  // Pulses are derived from ticks elapsed since the press rather than from a state machine.
  function automatic mdl_t step(mdl_t m, logic b, int div, int stb, int rd, int rr);
    mdl_t n = m;
    logic tick = (m.cyc % div) == div - 1;
    logic rise = 1'b0, fall = 1'b0;
    n.cyc = m.cyc + 1;
    n.s1 = b;
    n.s2 = m.s1;
    n.en = 1'b0;
    if (tick) begin
      if (m.s2 != m.lvl) begin
        n.run = m.run + 1;
        if (n.run == stb) begin
          n.lvl = m.s2;
          n.run = 0;
          rise = m.s2;
          fall = !m.s2;
        end
      end else n.run = 0;
    end
    if (rise && !m.held) begin
      n.en = 1'b1;
      n.held = 1'b1;
      n.tsp = 0;
    end else if (fall) n.held = 1'b0;
    else if (tick && m.held && rd > 0) begin
      n.tsp = m.tsp + 1;
      n.en = n.tsp == rd || (n.tsp > rd && (n.tsp - rd) % rr == 0);
    end
    n.ra = n.held && rd > 0 && n.tsp >= rd;
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ma <= '0;
      mb <= '0;
      mc <= '0;
    end else begin
      ma <= step(ma, button, 1, 4, 0, 1);
      mb <= step(mb, button, 1, 4, 8, 3);
      mc <= step(mc, button, 5, 2, 3, 2);
    end
  end

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    check("model_a_en", en_a, ma.en);
    check("model_a_lvl", lv_a, ma.lvl);
    check("model_a_act", ra_a, ma.ra);
    check("model_b_en", en_b, mb.en);
    check("model_b_lvl", lv_b, mb.lvl);
    check("model_b_act", ra_b, mb.ra);
    check("model_c_en", en_c, mc.en);
    check("model_c_lvl", lv_c, mc.lvl);
    check("model_c_act", ra_c, mc.ra);
  end

  initial begin
    reset = 1'b1;
    button = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    button = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      check("press_a_en", en_a, k == 6);
      check("press_a_lvl", lv_a, k >= 6);
      check("press_a_act", ra_a, 1'b0);
      check("rpt_b_en", en_b, k == 6 || k == 14 || k == 17 || k == 20 || k == 23);
      check("rpt_b_act", ra_b, k >= 14);
      check("pre_c_en", en_c, k == 10);
      check("pre_c_lvl", lv_c, k >= 10);
    end
    #2 reset = 1'b1;
    #1;
    check("rst_a_en", en_a, 1'b0);
    check("rst_a_lvl", lv_a, 1'b0);
    check("rst_b_en", en_b, 1'b0);
    check("rst_b_lvl", lv_b, 1'b0);
    check("rst_b_act", ra_b, 1'b0);
    check("rst_c_lvl", lv_c, 1'b0);
    button = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    button = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      check("repress_a_en", en_a, k == 6);
      check("repress_b_en", en_b, k == 6);
    end
    reset = 1'b1;
    button = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    for (int k = 1; k <= 34; k++) begin
      button = (k <= 3 || k >= 6) && k < 23;
      @(negedge clock);
      check("bounce_a_en", en_a, k == 11);
      check("bounce_a_lvl", lv_a, k >= 11 && k < 28);
      check("release_b_en", en_b, k == 11 || k == 19 || k == 22 || k == 25);
      check("release_b_lvl", lv_b, k >= 11 && k < 28);
      check("release_b_act", ra_b, k >= 19 && k < 28);
    end
    for (int s = 0; s < 300; s++) begin
      int dur;
      if ($urandom_range(0, 29) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      button = 1'($urandom_range(0, 1));
      dur = $urandom_range(0, 1) == 1 ? $urandom_range(1, 4) : $urandom_range(1, 60);
      repeat (dur) @(negedge clock);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
